// File: rtl/ex_mdu_stage.sv
// Execute stage: single-cycle ALU/branch/address logic plus an iterative
// multiply/divide unit that stalls the pipeline until its result is ready.
module ex_mdu_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic [4:0]      ALUop_i,
  input  logic [XLEN-1:0] Oprend1,
  input  logic [XLEN-1:0] Oprend2,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] LinkAddr,
  input  logic [31:0]     inst_i,
  input  logic [4:0]      WriteDataNum_i,
  input  logic            WriteReg_i,
  output logic [4:0]      WriteDataNum_o,
  output logic            WriteReg_o,
  output logic [XLEN-1:0] WriteData_o,
  output logic [4:0]      ALUop_o,
  output logic [XLEN-1:0] MemAddr_o,
  output logic [XLEN-1:0] Result,
  output logic            branch_flag_o,
  output logic [XLEN-1:0] NewPC,
  output logic            StallReq
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [4:0] OP_AND  = 5'b00100, OP_OR   = 5'b00101,
                         OP_XOR  = 5'b00110, OP_SLT  = 5'b00111,
                         OP_SLTU = 5'b00011, OP_SLL  = 5'b01000,
                         OP_SRL  = 5'b01001, OP_SRA  = 5'b01010,
                         OP_ADDI = 5'b01100, OP_ADD  = 5'b01101,
                         OP_SUB  = 5'b01110, OP_JAL  = 5'b10000,
                         OP_BEQ  = 5'b10001, OP_BLT  = 5'b10010,
                         OP_BNE  = 5'b10011, OP_BGE  = 5'b10110,
                         OP_BLTU = 5'b10111, OP_MUL  = 5'b11000,
                         OP_MULHU = 5'b11001, OP_DIV = 5'b11010,
                         OP_DIVU = 5'b11011, OP_REM  = 5'b11100,
                         OP_REMU = 5'b11101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  mdu_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;     // mul: {hi, lo} product; div: {remainder, quotient}
  logic [XLEN-1:0]     opb_q;   // multiplicand or divisor magnitude
  logic [2:0]          op_q;
  logic                neg_q, neg_r;

  logic [SH_W-1:0]     shamt;
  logic [XLEN-1:0]     pc_plus4;
  logic                eq, lt_s, lt_u, taken, is_ctrl;
  logic                is_mdu, is_div, is_sdiv, sgn_a, sgn_b;
  logic [XLEN-1:0]     mag_a, mag_b, mdu_res;
  logic signed [11:0]  imm_s;
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   mul_next, div_next;
  logic                unused_inst;

  assign unused_inst = ^inst_i[19:12];

  assign shamt    = Oprend2[SH_W-1:0];
  assign pc_plus4 = pc_i + XLEN'(4);
  assign eq       = (Oprend1 == Oprend2);
  assign lt_s     = ($signed(Oprend1) < $signed(Oprend2));
  assign lt_u     = (Oprend1 < Oprend2);

  assign is_mdu  = (ALUop_i[4:3] == 2'b11) && (ALUop_i[2:0] <= 3'd5);
  assign is_div  = is_mdu && (ALUop_i[2:1] != 2'b00);
  assign is_sdiv = (ALUop_i == OP_DIV) || (ALUop_i == OP_REM);
  assign sgn_a   = is_sdiv && Oprend1[XLEN-1];
  assign sgn_b   = is_sdiv && Oprend2[XLEN-1];
  assign mag_a   = sgn_a ? -Oprend1 : Oprend1;
  assign mag_b   = sgn_b ? -Oprend2 : Oprend2;

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_diff = div_sh - {1'b0, opb_q};
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                acc[XLEN-2:0], div_ge};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks use blocking with defaults first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opb_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (is_mdu) begin
          op_q  <= ALUop_i[2:0];
          cnt   <= CNT_W'(XLEN);
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          if (is_div && (Oprend2 == '0)) begin
            acc   <= {Oprend1, {XLEN{1'b1}}};
            state <= DONE;
          end else if (is_sdiv && (Oprend1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (Oprend2 == {XLEN{1'b1}})) begin
            acc   <= {{XLEN{1'b0}}, Oprend1};
            state <= DONE;
          end else begin
            acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : Oprend1)};
            opb_q <= is_div ? mag_b : Oprend2;
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= (op_q[2:1] == 2'b00) ? mul_next : div_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sign correction applied at the output so the accumulator stays unsigned.
  always_comb begin
    case (op_q)
      3'b000:         mdu_res = acc[XLEN-1:0];
      3'b001:         mdu_res = acc[2*XLEN-1:XLEN];
      3'b010, 3'b011: mdu_res = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:        mdu_res = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    taken   = 1'b0;
    is_ctrl = 1'b1;
    case (ALUop_i)
      OP_JAL:  taken = 1'b1;
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = lt_s;
      OP_BGE:  taken = !lt_s;
      OP_BLTU: taken = lt_u;
      default: is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    WriteData_o = '0;
    if (!rst) begin
      case (ALUop_i)
        OP_ADDI, OP_ADD: WriteData_o = Oprend1 + Oprend2;
        OP_SUB:  WriteData_o = Oprend1 - Oprend2;
        OP_SLL:  WriteData_o = Oprend1 << shamt;
        OP_SRL:  WriteData_o = Oprend1 >> shamt;
        OP_SRA:  WriteData_o = $signed(Oprend1) >>> shamt;
        OP_XOR:  WriteData_o = Oprend1 ^ Oprend2;
        OP_OR:   WriteData_o = Oprend1 | Oprend2;
        OP_AND:  WriteData_o = Oprend1 & Oprend2;
        OP_SLT:  WriteData_o = XLEN'(lt_s);
        OP_SLTU: WriteData_o = XLEN'(lt_u);
        OP_JAL:  WriteData_o = pc_plus4;
        OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU:
          if (state == DONE) WriteData_o = mdu_res;
        default: WriteData_o = '0;
      endcase
    end
  end

  assign imm_s = (inst_i[6:0] == 7'b0000011) ? inst_i[31:20]
                                             : {inst_i[31:25], inst_i[11:7]};
  assign MemAddr_o = Oprend1 + XLEN'(imm_s);

  assign StallReq       = !rst && !flush_i &&
                          (((state == IDLE) && is_mdu) || (state == BUSY));
  assign branch_flag_o  = !rst && !flush_i && taken && (LinkAddr != pc_plus4);
  assign NewPC          = (!rst && is_ctrl) ? LinkAddr : '0;
  assign WriteReg_o     = WriteReg_i && !rst && !flush_i && !StallReq;
  assign WriteDataNum_o = WriteDataNum_i;
  assign ALUop_o        = ALUop_i;
  assign Result         = Oprend2;

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed bench for ex_mdu_stage: ALU, branch, address, MDU timing,
// flush and reset-during-BUSY behaviour with hand-computed expectations.
module tb_ex_mdu_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush_i;
  logic [4:0]      ALUop_i;
  logic [XLEN-1:0] Oprend1, Oprend2, pc_i, LinkAddr;
  logic [31:0]     inst_i;
  logic [4:0]      WriteDataNum_i;
  logic            WriteReg_i;
  logic [4:0]      WriteDataNum_o, ALUop_o;
  logic            WriteReg_o, branch_flag_o, StallReq;
  logic [XLEN-1:0] WriteData_o, MemAddr_o, Result, NewPC;

  int n_checks = 0;
  int n_errors = 0;

  ex_mdu_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .ALUop_i(ALUop_i),
    .Oprend1(Oprend1), .Oprend2(Oprend2), .pc_i(pc_i), .LinkAddr(LinkAddr),
    .inst_i(inst_i), .WriteDataNum_i(WriteDataNum_i), .WriteReg_i(WriteReg_i),
    .WriteDataNum_o(WriteDataNum_o), .WriteReg_o(WriteReg_o),
    .WriteData_o(WriteData_o), .ALUop_o(ALUop_o), .MemAddr_o(MemAddr_o),
    .Result(Result), .branch_flag_o(branch_flag_o), .NewPC(NewPC),
    .StallReq(StallReq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUop_i = op;
    Oprend1 = a;
    Oprend2 = b;
    #1;
  endtask

  // Present an MDU op, count stall cycles (bounded), then check the result cycle.
  task automatic run_mdu(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int  n;
    logic wr_seen;
    apply(op, a, b);
    WriteReg_i = 1'b1;
    #1;
    n = 0;
    wr_seen = 1'b0;
    while (StallReq && n < 200) begin
      if (WriteReg_o) wr_seen = 1'b1;
      n++;
      step();
    end
    check({tag, " stall_cycles"}, n, exp_stall);
    check({tag, " wr_during_stall"}, wr_seen, 0);
    check({tag, " result"}, WriteData_o, exp);
    check({tag, " wr_result"}, WriteReg_o, 1);
    step();
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0;
    ALUop_i = 5'b11000; Oprend1 = 32'd7; Oprend2 = 32'd3;
    pc_i = 32'h1000; LinkAddr = 32'h2000; inst_i = 32'h0;
    WriteDataNum_i = 5'd5; WriteReg_i = 1'b1;
    step(); step();

    // Reset state with an MDU op presented
    check("rst stall", StallReq, 0);
    check("rst wr", WriteReg_o, 0);
    check("rst wdata", WriteData_o, 0);
    check("rst wnum", WriteDataNum_o, 5);
    apply(5'b10000, 32'h0, 32'h0);
    check("rst jal newpc", NewPC, 0);
    check("rst jal flag", branch_flag_o, 0);
    check("rst jal wdata", WriteData_o, 0);
    rst = 1'b0;
    step();

    // Single-cycle ALU
    apply(5'b01101, 32'h0000_0005, 32'h0000_0003);
    check("add", WriteData_o, 32'h8);
    check("add wr", WriteReg_o, 1);
    check("add stall", StallReq, 0);
    check("add newpc", NewPC, 0);
    check("aluop pass", ALUop_o, 5'b01101);
    check("store data", Result, 32'h3);
    apply(5'b01110, 32'h0000_0003, 32'h0000_0005);
    check("sub", WriteData_o, 32'hFFFF_FFFE);
    apply(5'b01010, 32'h8000_0000, 32'd4);
    check("sra", WriteData_o, 32'hF800_0000);
    apply(5'b01001, 32'h8000_0000, 32'd4);
    check("srl", WriteData_o, 32'h0800_0000);
    apply(5'b01000, 32'h0000_0003, 32'h0000_0024);
    check("sll shamt5", WriteData_o, 32'h30);
    apply(5'b00111, 32'hFFFF_FFFF, 32'h1);
    check("slt", WriteData_o, 32'h1);
    apply(5'b00011, 32'hFFFF_FFFF, 32'h1);
    check("sltu", WriteData_o, 32'h0);
    apply(5'b00110, 32'hF0F0_1234, 32'h0FF0_0034);
    check("xor", WriteData_o, 32'hFF00_1200);

    // Load/store effective address
    inst_i = 32'hFFC0_0003;
    apply(5'b10100, 32'h100, 32'h0);
    check("lw addr", MemAddr_o, 32'hFC);
    check("lw wdata", WriteData_o, 32'h0);
    inst_i = 32'hFE00_0C23;
    apply(5'b10101, 32'h200, 32'h55);
    check("sw addr", MemAddr_o, 32'h1F8);

    // Branches and jump
    apply(5'b10010, 32'hFFFF_FFFF, 32'h1);
    check("blt flag", branch_flag_o, 1);
    check("blt newpc", NewPC, 32'h2000);
    apply(5'b10111, 32'hFFFF_FFFF, 32'h1);
    check("bltu flag", branch_flag_o, 0);
    apply(5'b10110, 32'h1, 32'hFFFF_FFFF);
    check("bge flag", branch_flag_o, 1);
    apply(5'b10011, 32'h5, 32'h5);
    check("bne flag", branch_flag_o, 0);
    LinkAddr = 32'h1004;
    apply(5'b10001, 32'h5, 32'h5);
    check("beq fallthrough flag", branch_flag_o, 0);
    LinkAddr = 32'h2000;
    apply(5'b10000, 32'h0, 32'h0);
    check("jal wdata", WriteData_o, 32'h1004);
    check("jal flag", branch_flag_o, 1);
    step();

    // MDU
    run_mdu("mul",   5'b11000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_mdu("mulhu", 5'b11001, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
    run_mdu("div",   5'b11010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mdu("rem",   5'b11100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_mdu("div pos/neg", 5'b11010, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_mdu("rem pos/neg", 5'b11100, 32'd7, 32'hFFFF_FFFE, 32'h1, 33);
    run_mdu("divu",  5'b11011, 32'd100, 32'd7, 32'd14, 33);
    run_mdu("remu",  5'b11101, 32'd100, 32'd7, 32'd2, 33);
    run_mdu("div by0", 5'b11010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_mdu("rem by0", 5'b11100, 32'd5, 32'd0, 32'd5, 1);
    run_mdu("div ovf", 5'b11010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_mdu("rem ovf", 5'b11100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Flush in BUSY cycle 10
    apply(5'b11000, 32'd7, 32'hFFFF_FFFD);
    check("flush start stall", StallReq, 1);
    for (int i = 0; i < 10; i++) step();
    flush_i = 1'b1;
    #1;
    check("flush stall", StallReq, 0);
    check("flush wr", WriteReg_o, 0);
    step();
    flush_i = 1'b0;
    run_mdu("mul after flush", 5'b11000, 32'd3, 32'd5, 32'd15, 33);

    // Reset in BUSY
    apply(5'b11000, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    check("busy rst stall", StallReq, 0);
    check("busy rst wr", WriteReg_o, 0);
    check("busy rst wdata", WriteData_o, 0);
    step();
    apply(5'b10000, 32'h0, 32'h0);
    check("busy rst jal wdata", WriteData_o, 0);
    check("busy rst newpc", NewPC, 0);
    check("busy rst flag", branch_flag_o, 0);
    rst = 1'b0;
    step();
    run_mdu("divu after rst", 5'b11011, 32'd100, 32'd7, 32'd14, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
